clk_divider_mc: RTL and testbench
=================================

// Module: clk_divider_mc
// PURPOSE
//   Multi-channel programmable clock divider / strobe generator. Derives NUM_CH
//   independent divided outputs from one input clock; each channel has its own
//   ratio, mode and enable, reprogrammed at run time through a config write port.
//   Ratio/mode updates are glitch-free: they take effect only at a period boundary.
//   Sits beside the CPU clock tree to produce peripheral clocks and timer ticks.
// PARAMETERS
//   DATA_WIDTH  8  width of each channel's ratio value and counter
//   NUM_CH      4  number of channels (1..16)
//   CH_W        2  width of cfg_ch; must satisfy 2**CH_W >= NUM_CH
// PORTS
//   clk_in     in   1           input clock; all logic on rising edge
//   reset      in   1           synchronous, active-high reset
//   ch_en      in   NUM_CH      per-channel enable (level)
//   sync       in   1           one-cycle phase-align pulse for all channels
//   cfg_wr     in   1           config write strobe
//   cfg_ch     in   CH_W        channel index for the write
//   cfg_ratio  in   DATA_WIDTH  new ratio R
//   cfg_mode   in   1           0 = TOGGLE (square wave), 1 = PULSE (1-cycle strobe)
//   cfg_ack    out  1           1-cycle pulse: write accepted
//   cfg_err    out  1           1-cycle pulse: write rejected (cfg_ch >= NUM_CH)
//   clk_out    out  NUM_CH      divided outputs, registered
// BEHAVIOUR
//   - Per channel state: cnt, active ratio R_act, active mode, shadow ratio/mode, pending.
//   - Reset (priority over all): cnt=0, R_act=0, mode=TOGGLE, shadow=0, pending=0,
//     clk_out=0, cfg_ack=0, cfg_err=0.
//   - Terminal: cnt == R_act. Enabled channel: cnt increments each cycle, wraps to 0 at
//     terminal; period = R_act+1 cycles. No special case for R=0 or R=all-ones.
//   - TOGGLE: clk_out toggles on the edge after terminal -> period 2*(R_act+1),
//     50% duty. R=0 gives clk_in/2.
//   - PULSE: clk_out <= terminal every cycle -> high exactly 1 cycle in every R_act+1.
//     R=0 gives clk_out held high.
//   - Config: cfg_wr with cfg_ch < NUM_CH writes shadow ratio/mode, sets pending;
//     cfg_ack high next cycle. cfg_ch >= NUM_CH: no state change, cfg_err next cycle.
//     Back-to-back writes accepted every cycle; last write to a channel wins.
//   - Apply: pending channel copies shadow into R_act/mode at its terminal cycle
//     (terminal output event uses OLD mode), clears pending; new values govern from
//     the next cycle. A write in the same cycle as terminal is applied at the NEXT
//     terminal (pending sampled before the write).
//   - ch_en low: cnt held 0, clk_out <= 0 next cycle, pending applied immediately.
//     Re-enable: first terminal after R_act+1 cycles (first TOGGLE rise at cycle R_act+1).
//   - sync high: every channel cnt<=0, clk_out<=0, pending applied; overrides count and
//     terminal that cycle; config write in same cycle still lands in shadow.
//   - Priority: reset > sync > ch_en low > normal counting.
//   - Channels fully independent; no interaction other than sync.
// TESTING
//   1. Reset then ch_en=1, R=0 TOGGLE ch0 -> clk_out[0] toggles every cycle (clk/2).
//   2. ch1 R=4 TOGGLE -> period 10 cycles, 5 high/5 low; ch2 R=3 PULSE -> 1-cycle high
//      every 4 cycles; check simultaneously, no cross-talk.
//   3. ch0 R=9 running, write R=2 mid-period -> current 10-cycle half completes, then
//      3-cycle halves; no short/runt phase. Write on terminal cycle -> applied one period later.
//   4. Write cfg_ch=5 with NUM_CH=4 -> cfg_err pulse, cfg_ack 0, all outputs unchanged.
//   5. Channels R=2 and R=5 running, pulse sync -> both clk_out 0, counts restart aligned;
//      ch_en low mid-period -> clk_out 0 next cycle, new shadow applied at once.
//   6. reset asserted mid-operation -> all outputs 0 next edge, R_act=0, pending cleared.

Source files
------------

// File: rtl/clk_divider_mc_if.sv
// Configuration write port of the multi-channel clock divider.
// The master drives a write strobe with channel/ratio/mode; the slave answers with a one-cycle ack or err.
interface clk_divider_mc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_W       = 2
);
  logic                  cfg_wr;
  logic [CH_W-1:0]       cfg_ch;
  logic [DATA_WIDTH-1:0] cfg_ratio;
  logic                  cfg_mode;
  logic                  cfg_ack;
  logic                  cfg_err;

  modport master (
    output cfg_wr,
    output cfg_ch,
    output cfg_ratio,
    output cfg_mode,
    input  cfg_ack,
    input  cfg_err
  );

  modport slave (
    input  cfg_wr,
    input  cfg_ch,
    input  cfg_ratio,
    input  cfg_mode,
    output cfg_ack,
    output cfg_err
  );
endinterface

// File: rtl/clk_divider_mc.sv
// Multi-channel programmable divider: each channel emits a square wave or a one-cycle strobe.
// Ratio/mode changes are staged in a shadow copy and committed only at a period boundary.
module clk_divider_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  ch_en,
  input  logic               sync,
  clk_divider_mc_if.slave    cfg,
  output logic [NUM_CH-1:0]  clk_out
);

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  logic cfg_valid;
  logic cfg_ack_q, cfg_ack_d;
  logic cfg_err_q, cfg_err_d;

  assign cfg_valid = ({1'b0, cfg.cfg_ch} < (CH_W + 1)'(NUM_CH));

  always_comb begin
    cfg_ack_d = cfg.cfg_wr && cfg_valid;
    cfg_err_d = cfg.cfg_wr && !cfg_valid;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_ack_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg.cfg_ack = cfg_ack_q;
  assign cfg.cfg_err = cfg_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] ratio_q, ratio_d;
    logic [DATA_WIDTH-1:0] shadow_ratio_q, shadow_ratio_d;
    mode_e                 mode_q, mode_d;
    mode_e                 shadow_mode_q, shadow_mode_d;
    logic                  pending_q, pending_d;
    logic                  out_q, out_d;
    logic                  wr_hit;
    logic                  terminal;
    logic                  apply;

    assign wr_hit   = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(gi));
    assign terminal = (cnt_q == ratio_q);

    always_comb begin
      cnt_d          = cnt_q;
      ratio_d        = ratio_q;
      mode_d         = mode_q;
      out_d          = out_q;
      pending_d      = pending_q;
      shadow_ratio_d = shadow_ratio_q;
      shadow_mode_d  = shadow_mode_q;
      apply          = 1'b0;

      if (sync || !ch_en[gi]) begin
        // Idle/realign: restart the period and commit anything staged right away.
        cnt_d = '0;
        out_d = 1'b0;
        apply = pending_q;
      end else begin
        cnt_d = terminal ? '0 : cnt_q + 1'b1;
        if (mode_q == MODE_PULSE) begin
          out_d = terminal;
        end else begin
          out_d = out_q ^ terminal;
        end
        apply = pending_q && terminal;
      end

      // The commit uses the shadow as it was before this cycle's write, so a write
      // landing on a boundary stays pending until the following boundary.
      if (apply) begin
        ratio_d   = shadow_ratio_q;
        mode_d    = shadow_mode_q;
        pending_d = 1'b0;
      end

      if (wr_hit) begin
        shadow_ratio_d = cfg.cfg_ratio;
        shadow_mode_d  = mode_e'(cfg.cfg_mode);
        pending_d      = 1'b1;
      end
    end

    always_ff @(posedge clk_in) begin
      if (reset) begin
        cnt_q          <= '0;
        ratio_q        <= '0;
        mode_q         <= MODE_TOGGLE;
        shadow_ratio_q <= '0;
        shadow_mode_q  <= MODE_TOGGLE;
        pending_q      <= 1'b0;
        out_q          <= 1'b0;
      end else begin
        cnt_q          <= cnt_d;
        ratio_q        <= ratio_d;
        mode_q         <= mode_d;
        shadow_ratio_q <= shadow_ratio_d;
        shadow_mode_q  <= shadow_mode_d;
        pending_q      <= pending_d;
        out_q          <= out_d;
      end
    end

    assign clk_out[gi] = out_q;
  end

endmodule

// File: tb/tb_clk_divider_mc.sv
// Bench for clk_divider_mc: a cycle scoreboard fed by a behavioural model, plus
// directed period/duty measurements taken from the recorded output history.
module tb_clk_divider_mc;
  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int CW  = 3;

  logic           clk_in = 1'b0;
  logic           reset;
  logic           sync;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] clk_out;

  clk_divider_mc_if #(.DATA_WIDTH(DW), .CH_W(CW)) cfg_if ();

  clk_divider_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CH_W(CW)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .ch_en   (ch_en),
    .sync    (sync),
    .cfg     (cfg_if),
    .clk_out (clk_out)
  );

  always #5 clk_in = ~clk_in;

  int             n_tests = 0;
  int             n_fail  = 0;
  int             cyc     = 0;
  logic [5:0]     sb_q[$];
  logic [NCH-1:0] hist[$];
  int             runs[$];
  logic           runs_val[$];
  logic [5:0]     last_obs;

  int   m_cnt[NCH];
  int   m_r[NCH];
  int   m_sr[NCH];
  logic m_mode[NCH];
  logic m_sm[NCH];
  logic m_pend[NCH];
  logic m_out[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected state after the coming edge, from the current inputs.
  task automatic model_step();
    logic           hit, term, app, ea, ee;
    logic [NCH-1:0] eo;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_r[c] = 0; m_sr[c] = 0; m_mode[c] = 1'b0;
        m_sm[c] = 1'b0; m_pend[c] = 1'b0; m_out[c] = 1'b0;
      end
      ea = 1'b0;
      ee = 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        hit  = cfg_if.cfg_wr && (int'(cfg_if.cfg_ch) == c);
        term = (m_cnt[c] == m_r[c]);
        app  = m_pend[c] && (sync || !ch_en[c] || term);
        if (sync || !ch_en[c]) begin
          m_cnt[c] = 0;
          m_out[c] = 1'b0;
        end else if (term) begin
          m_cnt[c] = 0;
          m_out[c] = m_mode[c] ? 1'b1 : ~m_out[c];
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
          if (m_mode[c]) m_out[c] = 1'b0;
        end
        if (app) begin
          m_r[c] = m_sr[c]; m_mode[c] = m_sm[c]; m_pend[c] = 1'b0;
        end
        if (hit) begin
          m_sr[c] = int'(cfg_if.cfg_ratio); m_sm[c] = cfg_if.cfg_mode; m_pend[c] = 1'b1;
        end
      end
      ea = cfg_if.cfg_wr && (int'(cfg_if.cfg_ch) < NCH);
      ee = cfg_if.cfg_wr && (int'(cfg_if.cfg_ch) >= NCH);
    end
    for (int c = 0; c < NCH; c++) eo[c] = m_out[c];
    sb_q.push_back({ee, ea, eo});
  endtask

  task automatic step();
    logic [5:0] exp_v;
    model_step();
    @(posedge clk_in);
    #1;
    last_obs = {cfg_if.cfg_err, cfg_if.cfg_ack, clk_out};
    exp_v    = sb_q.pop_front();
    check($sformatf("sb_c%0d", cyc), last_obs, exp_v);
    hist.push_back(clk_out);
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cfg_write(input int ch, input int ratio, input logic mode);
    cfg_if.cfg_wr    = 1'b1;
    cfg_if.cfg_ch    = CW'(ch);
    cfg_if.cfg_ratio = DW'(ratio);
    cfg_if.cfg_mode  = mode;
    step();
    cfg_if.cfg_wr    = 1'b0;
    $display("[TB] cfg write ch=%0d ratio=%0d mode=%0b -> ack=%0b err=%0b",
             ch, ratio, mode, last_obs[4], last_obs[5]);
  endtask

  // cnt_val < 0 waits for the terminal cycle; need_out < 0 ignores the output level.
  task automatic wait_model(input int c, input int cnt_val, input int need_out);
    int  k;
    bit  hit;
    k = 0;
    hit = 1'b0;
    while (k < 300) begin
      hit = ((cnt_val < 0) ? (m_cnt[c] == m_r[c]) : (m_cnt[c] == cnt_val)) &&
            ((need_out < 0) || (int'(m_out[c]) == need_out));
      if (hit) break;
      step();
      k++;
    end
    check($sformatf("wait_ch%0d", c), 32'(hit), 32'd1);
  endtask

  // Full-length runs of bit b from index 'from' on, leading and trailing partial runs dropped.
  task automatic measure(input int b, input int from);
    int i;
    int len;
    runs.delete();
    runs_val.delete();
    i = from;
    while (i < hist.size() - 1 && hist[i][b] == hist[i+1][b]) i++;
    i++;
    len = 0;
    for (int k = i; k < hist.size() - 1; k++) begin
      len++;
      if (hist[k+1][b] != hist[k][b]) begin
        runs.push_back(len);
        runs_val.push_back(hist[k][b]);
        len = 0;
      end
    end
  endtask

  function automatic int first_high(input int b, input int from);
    for (int k = from + 1; k < hist.size(); k++)
      if (hist[k][b]) return k - from;
    return -1;
  endfunction

  function automatic int transitions(input int b, input int from, input int n);
    int t;
    t = 0;
    for (int k = from + 1; k < from + n && k < hist.size(); k++)
      if (hist[k][b] != hist[k-1][b]) t++;
    return t;
  endfunction

  initial begin
    int h, w, s, e, n_bad, n_hi;
    bit seen3;
    reset = 1'b1; sync = 1'b0; ch_en = '0;
    cfg_if.cfg_wr = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_ratio = '0; cfg_if.cfg_mode = 1'b0;
    @(negedge clk_in);

    // Reset, then ch0 with R=0 TOGGLE gives clk/2.
    run(2);
    check("reset_state", last_obs, 6'd0);
    reset = 1'b0;
    ch_en = 4'b0001;
    h = hist.size();
    run(8);
    n_hi = 0;
    for (int k = h; k < h + 8; k++) n_hi += int'(hist[k][0]);
    check("t1_highs", n_hi, 4);
    check("t1_toggles", transitions(0, h, 8), 7);

    // ch1 R=4 TOGGLE, ch2 R=3 PULSE, ch3 R=0 PULSE side by side.
    cfg_write(1, 4, 1'b0);
    cfg_write(2, 3, 1'b1);
    cfg_write(3, 0, 1'b1);
    ch_en = 4'b1111;
    h = hist.size();
    run(40);
    measure(1, h);
    n_bad = 0;
    foreach (runs[k]) if (runs[k] != 5) n_bad++;
    check("t2_ch1_halves", n_bad, 0);
    check("t2_ch1_nruns", 32'(runs.size() >= 6), 1);
    measure(2, h);
    n_bad = 0;
    foreach (runs[k]) if (runs[k] != (runs_val[k] ? 1 : 3)) n_bad++;
    check("t2_ch2_pulse", n_bad, 0);
    check("t2_ch2_nruns", 32'(runs.size() >= 10), 1);
    n_hi = 0;
    for (int k = h + 1; k < hist.size(); k++) n_hi += int'(hist[k][3]);
    check("t2_ch3_held", n_hi, hist.size() - h - 1);

    // ch0 R=9, then R=2 written mid-period: no runt half.
    cfg_write(0, 9, 1'b0);
    h = hist.size();
    run(30);
    wait_model(0, 4, -1);
    cfg_write(0, 2, 1'b0);
    run(30);
    measure(0, h + 2);
    n_bad = 0;
    seen3 = 1'b0;
    foreach (runs[k]) begin
      if (runs[k] != 10 && runs[k] != 3) n_bad++;
      if (runs[k] == 3) seen3 = 1'b1;
      else if (seen3) n_bad++;
    end
    check("t3_no_runt", n_bad, 0);
    check("t3_first10", runs[0], 10);
    check("t3_last3", runs[runs.size()-1], 3);

    // Write on a terminal cycle lands one period later.
    wait_model(0, -1, -1);
    w = hist.size();
    cfg_write(0, 5, 1'b0);
    run(20);
    measure(0, w - 1);
    check("t3_term_r0", runs[0], 3);
    check("t3_term_r1", runs[1], 6);
    check("t3_term_r2", runs[2], 6);

    // Out-of-range channel is rejected.
    cfg_write(5, 77, 1'b1);
    check("t4_err", last_obs[5], 1'b1);
    check("t4_ack", last_obs[4], 1'b0);
    run(16);

    // sync realigns ch0 (R=2), ch1 (R=5), ch2 (R=3 PULSE).
    cfg_write(0, 2, 1'b0);
    cfg_write(1, 5, 1'b0);
    run(20);
    sync = 1'b1;
    step();
    sync = 1'b0;
    s = hist.size() - 1;
    check("t5_sync_out", last_obs[3:0], 4'd0);
    run(12);
    check("t5_ch0_rise", first_high(0, s), 3);
    check("t5_ch1_rise", first_high(1, s), 6);
    check("t5_ch2_strobe", first_high(2, s), 4);

    // ch_en low mid-high-half with a pending write: output drops, shadow committed.
    wait_model(1, 2, 1);
    cfg_write(1, 1, 1'b0);
    ch_en = 4'b1101;
    step();
    check("t5_en_low", last_obs[1], 1'b0);
    step();
    ch_en = 4'b1111;
    e = hist.size();
    run(12);
    check("t5_reen_rise", first_high(1, e), 1);
    measure(1, e + 1);
    check("t5_reen_h0", runs[0], 2);
    check("t5_reen_h1", runs[1], 2);

    // Reset mid-operation clears pending and ratios.
    cfg_write(1, 9, 1'b0);
    reset = 1'b1;
    step();
    check("t6_reset", last_obs, 6'd0);
    reset = 1'b0;
    h = hist.size();
    run(6);
    check("t6_ch1_div2", transitions(1, h, 6), 5);
    check("t6_ch2_div2", transitions(2, h, 6), 5);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) ch_en = NCH'($urandom);
      sync = ($urandom_range(0, 31) == 0);
      cfg_if.cfg_wr    = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_ch    = CW'($urandom_range(0, 7));
      cfg_if.cfg_ratio = ($urandom_range(0, 15) == 0) ? 8'hFF : DW'($urandom_range(0, 15));
      cfg_if.cfg_mode  = 1'($urandom_range(0, 1));
      step();
    end
    cfg_if.cfg_wr = 1'b0;
    sync = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
